// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encodings,
// command mode encodings and a helper that folds the reserved mode.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_FREE    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Mode 11 behaves exactly like one-shot, so fold it on capture.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_RELOAD;
            2'd2:    m = MODE_FREE;
            default: m = MODE_ONESHOT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/counter_sequencer_core.sv
// Counter datapath: WIDTH-bit register with synchronous load (priority)
// and count enable. wrap_o flags an increment from all-ones to zero.
module counter_sequencer_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over increment; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o    = cnt_q;
    assign wrap_o = en_i && !load_i && (&cnt_q);

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer around a WIDTH-bit up-counter.
// Optional feature macro: COUNTER_PRESCALE_EN (count ticks every PRESCALE
// cycles instead of every cycle).
// Handshake: a command is accepted on a rising edge where input_CMD_VALID
// and output_CMD_READY are both high; READY is high exactly in IDLE, so a
// requester must hold VALID until it sees READY.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             input_CLK,
    input  logic             input_RST,
    input  logic             input_CMD_VALID,
    output logic             output_CMD_READY,
    input  logic [WIDTH-1:0] input_START,
    input  logic [WIDTH-1:0] input_LIMIT,
    input  logic [1:0]       input_MODE,
    input  logic             input_ABORT,
    output logic [WIDTH-1:0] output_Y,
    output logic             output_BUSY,
    output logic             output_DONE,
    output logic             output_OVERFLOW
);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] limit_q;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             cap_en;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_wrap;
    logic             tick;
    logic [WIDTH-1:0] y;

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    // Prescaler restarts in LOAD and rolls over on each tick while running.
    always_comb begin
        ps_d = ps_q;
        if (state_q == ST_LOAD) begin
            ps_d = '0;
        end else if (state_q == ST_RUN) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge input_CLK or posedge input_RST) begin
        if (input_RST) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    // Without the prescaler every cycle is a tick (PRESCALE is always >= 1).
    assign tick = (PRESCALE >= 1);
`endif

    counter_sequencer_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i     (input_CLK),
        .rst_i     (input_RST),
        .load_i    (cnt_load),
        .load_val_i(start_q),
        .en_i      (cnt_en),
        .q_o       (y),
        .wrap_o    (cnt_wrap)
    );

    // Next-state, counter controls and completion pulse; ABORT beats completion.
    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (input_CMD_VALID) begin
                    cap_en  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (input_ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (input_ABORT) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    case (mode_q)
                        MODE_FREE: begin
                            cnt_en = 1'b1;
                        end
                        MODE_RELOAD: begin
                            if (y == limit_q) begin
                                cnt_load = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
                        default: begin
                            if (y == limit_q) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow is sticky until the next accepted command clears it.
    always_comb begin
        ovf_d = ovf_q | cnt_wrap;
        if (cap_en) begin
            ovf_d = 1'b0;
        end
    end

    // State, command capture and flag registers.
    always_ff @(posedge input_CLK or posedge input_RST) begin
        if (input_RST) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            start_q <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (cap_en) begin
                mode_q  <= decode_mode(input_MODE);
                start_q <= input_START;
                limit_q <= input_LIMIT;
            end
        end
    end

    assign output_CMD_READY = (state_q == ST_IDLE);
    assign output_BUSY      = (state_q != ST_IDLE);
    assign output_DONE      = done_q;
    assign output_OVERFLOW  = ovf_q;
    assign output_Y         = y;

endmodule
